// File: rtl/elevator_scan_ctrl.sv
// N-floor collective (SCAN) elevator controller: latches cabin and hall calls, keeps its
// travel direction while calls lie ahead, and drives motor, floor display and door.
module elevator_scan_ctrl #(
  parameter int FLOORS      = 4,
  parameter int DOOR_CYCLES = 4,
  parameter int FW          = $clog2(FLOORS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] sensor,
  input  logic [FLOORS-1:0] car_req,
  input  logic [FLOORS-1:0] hall_up,
  input  logic [FLOORS-1:0] hall_dn,
  output logic [1:0]        ac,
  output logic [FW-1:0]     display,
  output logic              doorOpen,
  output logic [FLOORS-1:0] pending
);
  localparam int TW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [FW-1:0]     TOP    = FW'(FLOORS - 1);
  localparam logic [FW-1:0]     BOT    = {FW{1'b0}};
  localparam logic [TW-1:0]     DWELL  = TW'(DOOR_CYCLES - 1);
  localparam logic              DIR_UP = 1'b1;
  localparam logic              DIR_DN = 1'b0;
  localparam logic [FLOORS-1:0] UP_OK  = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DN_OK  = {{(FLOORS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE = 2'd0, MOVE_UP = 2'd1, MOVE_DN = 2'd2, DOOR = 2'd3} state_t;

  state_t            state_q, state_d, dep_state_s;
  logic [FW-1:0]     floor_q, floor_d;
  logic              dir_q, dir_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [FLOORS-1:0] car_q, car_d, up_q, up_d, dn_q, dn_d;

  logic [FLOORS-1:0] hall_up_s, hall_dn_s, all_s, cand_up_s, cand_dn_s;
  logic [FLOORS-1:0] clr_car_s, clr_up_s, clr_dn_s, sup_car_s, sup_up_s, sup_dn_s;
  logic [FW-1:0]     j_lo_s, j_hi_s, j_sel_s;
  logic              dir_eff_s, up_ahead_s, dn_ahead_s, fwd_s, rev_s, dep_dir_s;
  logic              mv_up_s, j_hit_s, beyond_s, stop_s, no_calls_s, restart_s;

  function automatic logic [FLOORS-1:0] above_mask(input logic [FW-1:0] f);
    logic [FLOORS-1:0] m;
    for (int k = 0; k < FLOORS; k++) m[k] = (k > int'(f));
    return m;
  endfunction

  function automatic logic [FLOORS-1:0] below_mask(input logic [FW-1:0] f);
    logic [FLOORS-1:0] m;
    for (int k = 0; k < FLOORS; k++) m[k] = (k < int'(f));
    return m;
  endfunction

  assign hall_up_s  = hall_up & UP_OK;
  assign hall_dn_s  = hall_dn & DN_OK;
  assign all_s      = car_q | up_q | dn_q;
  assign up_ahead_s = |(all_s & above_mask(floor_q));
  assign dn_ahead_s = |(all_s & below_mask(floor_q));
  assign no_calls_s = ~|all_s;

  // Arrival floor: nearest sensor ahead of the car, and whether the car must stop there.
  always_comb begin
    cand_up_s = sensor & above_mask(floor_q);
    cand_dn_s = sensor & below_mask(floor_q);
    j_lo_s    = floor_q;
    j_hi_s    = floor_q;
    for (int k = FLOORS - 1; k >= 0; k--) j_lo_s = cand_up_s[k] ? FW'(k) : j_lo_s;
    for (int k = 0; k < FLOORS; k++)      j_hi_s = cand_dn_s[k] ? FW'(k) : j_hi_s;
    mv_up_s  = (state_q == MOVE_UP);
    j_sel_s  = mv_up_s ? j_lo_s : j_hi_s;
    j_hit_s  = mv_up_s ? (|cand_up_s) : ((state_q == MOVE_DN) && (|cand_dn_s));
    beyond_s = mv_up_s ? (|(all_s & above_mask(j_sel_s))) : (|(all_s & below_mask(j_sel_s)));
    stop_s   = car_q[j_sel_s] | (mv_up_s ? up_q[j_sel_s] : dn_q[j_sel_s])
             | (~beyond_s & (mv_up_s ? dn_q[j_sel_s] : up_q[j_sel_s]));
  end

  // Next state: FSM transitions, served-call clears and door-time call absorption.
  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_d     = dir_q;
    timer_d   = timer_q;
    clr_car_s = {FLOORS{1'b0}};
    clr_up_s  = {FLOORS{1'b0}};
    clr_dn_s  = {FLOORS{1'b0}};
    sup_car_s = {FLOORS{1'b0}};
    sup_up_s  = {FLOORS{1'b0}};
    sup_dn_s  = {FLOORS{1'b0}};
    restart_s = 1'b0;
    if (floor_q == TOP)      dir_eff_s = DIR_DN;
    else if (floor_q == BOT) dir_eff_s = DIR_UP;
    else                     dir_eff_s = dir_q;
    fwd_s     = dir_eff_s ? up_ahead_s : dn_ahead_s;
    rev_s     = dir_eff_s ? dn_ahead_s : up_ahead_s;
    dep_dir_s = (fwd_s || !rev_s) ? dir_eff_s : ~dir_eff_s;
    if (!(fwd_s || rev_s)) dep_state_s = IDLE;
    else if (dep_dir_s)    dep_state_s = MOVE_UP;
    else                   dep_state_s = MOVE_DN;
    case (state_q)
      IDLE: begin
        if (all_s[floor_q]) begin
          state_d              = DOOR;
          timer_d              = DWELL;
          clr_car_s[floor_q]   = 1'b1;
          clr_up_s[floor_q]    = 1'b1;
          clr_dn_s[floor_q]    = 1'b1;
        end else begin
          state_d = dep_state_s;
          dir_d   = dep_dir_s;
        end
      end
      MOVE_UP, MOVE_DN: begin
        if (j_hit_s) begin
          floor_d = j_sel_s;
          if (stop_s) begin
            state_d            = DOOR;
            timer_d            = DWELL;
            clr_car_s[j_sel_s] = 1'b1;
            clr_up_s[j_sel_s]  = mv_up_s | ~beyond_s;
            clr_dn_s[j_sel_s]  = ~mv_up_s | ~beyond_s;
          end else if (!beyond_s) begin
            state_d = IDLE;
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      DOOR: begin
        sup_car_s[floor_q] = 1'b1;
        sup_up_s[floor_q]  = dir_eff_s | no_calls_s;
        sup_dn_s[floor_q]  = ~dir_eff_s | no_calls_s;
        restart_s = |((car_req & sup_car_s) | (hall_up_s & sup_up_s) | (hall_dn_s & sup_dn_s));
        if (restart_s) begin
          timer_d = DWELL;
        end else if (timer_q == {TW{1'b0}}) begin
          state_d = dep_state_s;
          dir_d   = dep_dir_s;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (floor_d == TOP)      dir_d = DIR_DN;
    else if (floor_d == BOT) dir_d = DIR_UP;
    else                     dir_d = dir_d;
    car_d = (car_q | car_req)   & ~clr_car_s & ~sup_car_s;
    up_d  = (up_q  | hall_up_s) & ~clr_up_s  & ~sup_up_s;
    dn_d  = (dn_q  | hall_dn_s) & ~clr_dn_s  & ~sup_dn_s;
  end

  // State and call-latch registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      floor_q <= {FW{1'b0}};
      dir_q   <= DIR_UP;
      timer_q <= {TW{1'b0}};
      car_q   <= {FLOORS{1'b0}};
      up_q    <= {FLOORS{1'b0}};
      dn_q    <= {FLOORS{1'b0}};
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
      car_q   <= car_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
    end
  end

  // Outputs decoded from registered state.
  always_comb begin
    case (state_q)
      MOVE_UP: ac = 2'b01;
      MOVE_DN: ac = 2'b10;
      default: ac = 2'b00;
    endcase
    display  = floor_q;
    doorOpen = (state_q == DOOR);
    pending  = all_s;
  end
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Scoreboard bench for elevator_scan_ctrl: a call-list reference model predicts the outputs
// after every edge; a monitor compares them against the DUT.
module tb_elevator_scan_ctrl;
  localparam int F  = 4;
  localparam int D  = 4;
  localparam int FW = $clog2(F);
  localparam int M_IDLE = 0, M_UP = 1, M_DN = 2, M_DOOR = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [F-1:0]  sensor = '0, car_req = '0, hall_up = '0, hall_dn = '0;
  logic [1:0]    ac;
  logic [FW-1:0] display;
  logic          doorOpen;
  logic [F-1:0]  pending;

  elevator_scan_ctrl #(.FLOORS(F), .DOOR_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .sensor(sensor), .car_req(car_req), .hall_up(hall_up),
    .hall_dn(hall_dn), .ac(ac), .display(display), .doorOpen(doorOpen), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    ac;
    logic [FW-1:0] disp;
    logic          door;
    logic [F-1:0]  pend;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Reference model: call lists per floor, a motion mode and a door countdown.
  bit m_car[F], m_up[F], m_dn[F];
  int m_mode = M_IDLE, m_floor = 0, m_left = 0;
  bit m_dir = 1'b1;

  function automatic bit any_at(int k);
    return m_car[k] || m_up[k] || m_dn[k];
  endfunction

  function automatic bit any_beyond(int f, bit up);
    for (int k = 0; k < F; k++)
      if (((up && k > f) || (!up && k < f)) && any_at(k)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic depart(bit edir);
    if (any_beyond(m_floor, edir)) begin
      m_mode = edir ? M_UP : M_DN; m_dir = edir;
    end else if (any_beyond(m_floor, !edir)) begin
      m_mode = edir ? M_DN : M_UP; m_dir = !edir;
    end else begin
      m_mode = M_IDLE;
    end
  endtask

  task automatic model_step(bit r, logic [F-1:0] c, logic [F-1:0] u, logic [F-1:0] d, logic [F-1:0] s);
    bit nc[F], nu[F], nd[F], cc[F], cu[F], cd[F];
    bit edir, none, beyond, hit, goes_up;
    int j;
    if (!r) begin
      for (int k = 0; k < F; k++) begin m_car[k] = 0; m_up[k] = 0; m_dn[k] = 0; end
      m_mode = M_IDLE; m_floor = 0; m_dir = 1'b1; m_left = 0;
      return;
    end
    none = 1'b1;
    for (int k = 0; k < F; k++) begin
      nc[k] = c[k]; nu[k] = u[k] && (k != F - 1); nd[k] = d[k] && (k != 0);
      cc[k] = 0; cu[k] = 0; cd[k] = 0;
      if (any_at(k)) none = 1'b0;
    end
    edir = (m_floor == F - 1) ? 1'b0 : (m_floor == 0) ? 1'b1 : m_dir;
    case (m_mode)
      M_IDLE: begin
        if (any_at(m_floor)) begin
          m_mode = M_DOOR; m_left = D;
          cc[m_floor] = 1; cu[m_floor] = 1; cd[m_floor] = 1;
        end else depart(edir);
      end
      M_UP, M_DN: begin
        goes_up = (m_mode == M_UP);
        j = -1;
        for (int k = 0; k < F; k++)
          if (s[k] && (goes_up ? (k > m_floor) : (k < m_floor)))
            if (j < 0 || !goes_up) j = k;
        if (j >= 0) begin
          beyond  = any_beyond(j, goes_up);
          m_floor = j;
          if (m_car[j] || (goes_up ? m_up[j] : m_dn[j]) || (!beyond && (goes_up ? m_dn[j] : m_up[j]))) begin
            m_mode = M_DOOR; m_left = D;
            cc[j] = 1; cu[j] = goes_up || !beyond; cd[j] = !goes_up || !beyond;
          end else if (!beyond) m_mode = M_IDLE;
        end
      end
      default: begin
        hit = nc[m_floor] || (nu[m_floor] && (edir || none)) || (nd[m_floor] && (!edir || none));
        nc[m_floor] = 0;
        if (edir || none)  nu[m_floor] = 0;
        if (!edir || none) nd[m_floor] = 0;
        if (hit) m_left = D;
        else if (m_left == 1) depart(edir);
        else m_left--;
      end
    endcase
    for (int k = 0; k < F; k++) begin
      m_car[k] = (m_car[k] || nc[k]) && !cc[k];
      m_up[k]  = (m_up[k]  || nu[k]) && !cu[k];
      m_dn[k]  = (m_dn[k]  || nd[k]) && !cd[k];
    end
    if (m_floor == F - 1) m_dir = 1'b0;
    else if (m_floor == 0) m_dir = 1'b1;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.ac   = (m_mode == M_UP) ? 2'b01 : (m_mode == M_DN) ? 2'b10 : 2'b00;
    o.disp = FW'(m_floor);
    o.door = (m_mode == M_DOOR);
    for (int k = 0; k < F; k++) o.pend[k] = any_at(k);
    return o;
  endfunction

  task automatic step(bit r, logic [F-1:0] c, logic [F-1:0] u, logic [F-1:0] d, logic [F-1:0] s);
    @(negedge clk);
    rst = r; car_req = c; hall_up = u; hall_dn = d; sensor = s;
    model_step(r, c, u, d, s);
    exp_q.push_back(model_obs());
    @(posedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b1, '0, '0, '0, '0);
  endtask

  task automatic arrive(int k);
    logic [F-1:0] s;
    s = '0;
    s[k] = 1'b1;
    step(1'b1, '0, '0, '0, s);
  endtask

  // Monitor: compare every post-edge DUT output with the oldest prediction.
  always begin
    @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if ({ac, display, doorOpen, pending} !== mon_e) begin
        errors++;
        $display("FAIL outputs t=%0t: got ac=%b display=%0d door=%b pending=%b, expected ac=%b display=%0d door=%b pending=%b",
                 $time, ac, display, doorOpen, pending, mon_e.ac, mon_e.disp, mon_e.door, mon_e.pend);
      end
    end
  end

  initial begin
    logic [F-1:0] c, u, d, s;
    bit r;
    step(1'b0, '0, '0, '0, '0);
    step(1'b0, '0, '0, '0, '0);
    idle(1);
    step(1'b1, '0, 4'b0100, '0, '0);
    idle(2); arrive(1); idle(1); arrive(2); idle(6);
    step(1'b1, 4'b1000, '0, '0, '0);
    idle(2); arrive(3); idle(6);
    step(1'b1, 4'b0001, 4'b0010, '0, '0);
    idle(2); arrive(2); idle(1); arrive(1); idle(1); arrive(0); idle(6); arrive(1); idle(6);
    step(1'b1, 4'b0010, '0, '0, '0);
    idle(2);
    step(1'b1, 4'b0010, '0, '0, '0);
    idle(7);
    step(1'b1, '0, 4'b1000, 4'b0001, '0);
    arrive(3); idle(3);
    step(1'b1, 4'b1000, '0, '0, '0);
    idle(2);
    step(1'b0, '0, '0, '0, '0);
    idle(3);
    for (int n = 0; n < 2500; n++) begin
      c = ($urandom_range(0, 9) == 0) ? (F'(1) << $urandom_range(0, F - 1)) : '0;
      u = ($urandom_range(0, 11) == 0) ? (F'(1) << $urandom_range(0, F - 1)) : '0;
      d = ($urandom_range(0, 11) == 0) ? (F'(1) << $urandom_range(0, F - 1)) : '0;
      s = '0;
      if (m_mode == M_UP && m_floor < F - 1 && $urandom_range(0, 2) == 0) s[m_floor + 1] = 1'b1;
      else if (m_mode == M_DN && m_floor > 0 && $urandom_range(0, 2) == 0) s[m_floor - 1] = 1'b1;
      if ($urandom_range(0, 24) == 0) s[$urandom_range(0, F - 1)] = 1'b1;
      r = ($urandom_range(0, 299) != 0);
      step(r, c, u, d, s);
    end
    idle(1);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked predictions, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
